// File: rtl/i8bit_div_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
// Optional build macro: DIV_EARLY_OUT_EN (divide-by-zero/overflow skip the iteration phase).
package i8bit_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH);
  // Wide enough for any practical WIDTH; users slice the low bits.
  localparam logic [63:0] Q_FORCED = '1;

endpackage

// File: rtl/i8bit_div_step.sv
// One combinational restoring step: shift in a dividend bit, subtract if it fits.
module i8bit_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] part_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;

  assign sh     = {part_i, bit_i};
  // The true difference is always below 2^WIDTH when it is taken, so modulo math is exact.
  assign diff   = sh[WIDTH-1:0] - div_i;
  assign qbit_o = sh[WIDTH] | (sh[WIDTH-1:0] >= div_i);
  assign part_o = qbit_o ? diff : sh[WIDTH-1:0];

endmodule

// File: rtl/i8bit_div.sv
// Sequential 16-by-8 unsigned restoring divider with valid/ready handshakes.
// Build option DIV_EARLY_OUT_EN: flagged (dbz/ovf) operations go straight to DONE.
module i8bit_div
  import i8bit_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_lo,
  input  logic [WIDTH-1:0] a_hi,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = Q_FORCED[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d, dvd_q, dvd_d, alo_q, alo_d, b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             fovf_q, fovf_d, fdbz_q, fdbz_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] part_nxt;
  logic             q_bit;
  logic             acc_dbz, acc_ovf;

  assign acc_dbz = (b == '0);
  assign acc_ovf = !acc_dbz && (a_hi >= b);

  i8bit_div_step #(.WIDTH(WIDTH)) u_step (
    .part_i (part_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .div_i  (b_q),
    .part_o (part_nxt),
    .qbit_o (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    alo_d   = alo_q;
    b_d     = b_q;
    fovf_d  = fovf_q;
    fdbz_d  = fdbz_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        part_d  = a_hi;
        dvd_d   = a_lo;
        alo_d   = a_lo;
        b_d     = b;
        cnt_d   = '0;
        fovf_d  = acc_ovf;
        fdbz_d  = acc_dbz;
        state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
        if (acc_dbz || acc_ovf) begin
          state_d = DONE;
          q_d     = ONES;
          r_d     = acc_dbz ? a_lo : '0;
          ovf_d   = acc_ovf;
          dbz_d   = acc_dbz;
        end
`endif
      end
      CALC: begin
        // dvd_q doubles as the quotient accumulator: dividend bits leave at the top,
        // quotient bits enter at the bottom.
        part_d = part_nxt;
        dvd_d  = {dvd_q[WIDTH-2:0], q_bit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          ovf_d   = fovf_q;
          dbz_d   = fdbz_q;
          if (fdbz_q) begin
            q_d = ONES;
            r_d = alo_q;
          end else if (fovf_q) begin
            q_d = ONES;
            r_d = '0;
          end else begin
            q_d = {dvd_q[WIDTH-2:0], q_bit};
            r_d = part_nxt;
          end
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvd_q   <= '0;
      alo_q   <= '0;
      b_q     <= '0;
      fovf_q  <= 1'b0;
      fdbz_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      alo_q   <= alo_d;
      b_q     <= b_d;
      fovf_q  <= fovf_d;
      fdbz_q  <= fdbz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule
